// File: rtl/switch_request_unit.sv
// Switch-allocator front end: builds credit-gated request rows, resolves the
// same-cycle grant matrix into pops, credit debits and a registered crossbar setup.
module switch_request_unit_col #(
    parameter int AGENTS_NUM  = 4,
    parameter int BUFFER_SIZE = 8,
    parameter int AW          = 2,
    parameter int CW          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] i_legal,
    input  logic                  i_credit,
    output logic [AGENTS_NUM-1:0] o_acc,
    output logic                  o_multi,
    output logic                  o_ovf,
    output logic [CW-1:0]         o_credits,
    output logic [AW-1:0]         o_sel,
    output logic                  o_valid
);
    logic [CW-1:0] r_cred;
    logic [AW-1:0] r_sel;
    logic          r_valid;
    logic [AW-1:0] w_sel;
    logic          w_take;

    // Two or more legal grants on one output are discarded as a whole.
    assign o_multi = (i_legal & (i_legal - AGENTS_NUM'(1))) != '0;
    assign o_acc   = o_multi ? '0 : i_legal;
    assign w_take  = |o_acc;
    assign o_ovf   = i_credit && !w_take && (r_cred == CW'(BUFFER_SIZE));

    always_comb begin
        w_sel = '0;
        for (int a = 0; a < AGENTS_NUM; a++)
            if (o_acc[a]) w_sel = AW'(a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cred  <= CW'(BUFFER_SIZE);
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_take;
            if (w_take) r_sel <= w_sel;
            if (!o_ovf) r_cred <= r_cred - CW'(w_take) + CW'(i_credit);
        end
    end

    assign o_credits = r_cred;
    assign o_sel     = r_sel;
    assign o_valid   = r_valid;
endmodule

module switch_request_unit #(
    parameter int AGENTS_NUM    = 4,
    parameter int RESOURCES_NUM = 6,
    parameter int BUFFER_SIZE   = 8
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic [AGENTS_NUM-1:0]                                      valid_i,
    input  logic [AGENTS_NUM-1:0][$clog2(RESOURCES_NUM)-1:0]           out_port_i,
    input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]                   grants_i,
    input  logic [RESOURCES_NUM-1:0]                                   credit_i,
    output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]                   requests_o,
    output logic [AGENTS_NUM-1:0]                                      read_o,
    output logic [RESOURCES_NUM-1:0][$clog2(AGENTS_NUM)-1:0]           xbar_sel_o,
    output logic [RESOURCES_NUM-1:0]                                   xbar_valid_o,
    output logic [RESOURCES_NUM-1:0][$clog2(BUFFER_SIZE+1)-1:0]        credits_o,
    output logic                                                       error_o
);
    localparam int RW = $clog2(RESOURCES_NUM);
    localparam int AW = $clog2(AGENTS_NUM);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] w_req;
    logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] w_acc;
    logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] w_legal_t;
    logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] w_acc_t;
    logic [RESOURCES_NUM-1:0]                 w_multi;
    logic [RESOURCES_NUM-1:0]                 w_ovf;
    logic                                     w_stray;
    logic                                     r_error;

    generate
        for (genvar a = 0; a < AGENTS_NUM; a++) begin : g_agent
            for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_res
                // Out-of-range routes simply never match a column.
                assign w_req[a][r] = valid_i[a] && (out_port_i[a] == RW'(r)) &&
                                     (credits_o[r] != '0);
                assign w_legal_t[r][a] = grants_i[a][r] & w_req[a][r];
                assign w_acc[a][r]     = w_acc_t[r][a];
            end
            assign read_o[a] = |w_acc[a];
        end

        for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_col
            switch_request_unit_col #(
                .AGENTS_NUM (AGENTS_NUM),
                .BUFFER_SIZE(BUFFER_SIZE),
                .AW         (AW),
                .CW         (CW)
            ) u_col (
                .clk      (clk),
                .rst      (rst),
                .i_legal  (w_legal_t[r]),
                .i_credit (credit_i[r]),
                .o_acc    (w_acc_t[r]),
                .o_multi  (w_multi[r]),
                .o_ovf    (w_ovf[r]),
                .o_credits(credits_o[r]),
                .o_sel    (xbar_sel_o[r]),
                .o_valid  (xbar_valid_o[r])
            );
        end
    endgenerate

    assign requests_o = w_req;
    assign w_stray    = |(grants_i & ~w_req);

    always_ff @(posedge clk) begin
        if (rst) r_error <= 1'b0;
        else     r_error <= r_error | w_stray | (|w_multi) | (|w_ovf);
    end

    assign error_o = r_error;
endmodule

// File: tb/tb_switch_request_unit.sv
// Directed bench for switch_request_unit with a per-cycle reference model.
module tb_switch_request_unit;
    localparam int A  = 4;
    localparam int R  = 6;
    localparam int B  = 8;
    localparam int RW = $clog2(R);
    localparam int AW = $clog2(A);
    localparam int CW = $clog2(B + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [A-1:0]             valid_i;
    logic [A-1:0][RW-1:0]     out_port_i;
    logic [A-1:0][R-1:0]      grants_i;
    logic [R-1:0]             credit_i;
    logic [A-1:0][R-1:0]      requests_o;
    logic [A-1:0]             read_o;
    logic [R-1:0][AW-1:0]     xbar_sel_o;
    logic [R-1:0]             xbar_valid_o;
    logic [R-1:0][CW-1:0]     credits_o;
    logic                     error_o;

    switch_request_unit #(.AGENTS_NUM(A), .RESOURCES_NUM(R), .BUFFER_SIZE(B)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .out_port_i(out_port_i),
        .grants_i(grants_i), .credit_i(credit_i), .requests_o(requests_o),
        .read_o(read_o), .xbar_sel_o(xbar_sel_o), .xbar_valid_o(xbar_valid_o),
        .credits_o(credits_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: credit counts, crossbar state, sticky error.
    int   m_cred [R];
    int   m_xs   [R];
    bit   m_xv   [R];
    bit   m_err;
    bit   chk_en = 0;
    logic [A-1:0][R-1:0]  e_req;
    logic [A-1:0]         e_rd;
    logic [R-1:0][CW-1:0] e_cred;
    logic [R-1:0][AW-1:0] e_xs;
    logic [R-1:0]         e_xv;
    bit   acc [R];
    int   who [R];
    bit   bad;
    int   n;

    always @(negedge clk) begin
        e_req = '0;
        for (int a = 0; a < A; a++)
            if (valid_i[a] && int'(out_port_i[a]) < R && m_cred[int'(out_port_i[a])] > 0)
                e_req[a][out_port_i[a]] = 1'b1;
        e_rd = '0;
        bad  = 0;
        for (int r = 0; r < R; r++) begin
            n = 0; acc[r] = 0; who[r] = 0;
            for (int a = 0; a < A; a++)
                if (grants_i[a][r]) begin
                    if (e_req[a][r]) begin n++; who[r] = a; end
                    else bad = 1;
                end
            if (n > 1) bad = 1;
            else if (n == 1) begin acc[r] = 1; e_rd[who[r]] = 1'b1; end
        end
        for (int r = 0; r < R; r++) begin
            e_cred[r] = CW'(m_cred[r]);
            e_xs[r]   = AW'(m_xs[r]);
            e_xv[r]   = m_xv[r];
        end
        if (chk_en) begin
            chk("requests", 64'(requests_o), 64'(e_req));
            chk("read", 64'(read_o), 64'(e_rd));
            chk("credits", 64'(credits_o), 64'(e_cred));
            chk("xbar_sel", 64'(xbar_sel_o), 64'(e_xs));
            chk("xbar_valid", 64'(xbar_valid_o), 64'(e_xv));
            chk("error", 64'(error_o), 64'(m_err));
        end
        if (rst) begin
            for (int r = 0; r < R; r++) begin m_cred[r] = B; m_xs[r] = 0; m_xv[r] = 0; end
            m_err  = 0;
            chk_en = 1;
        end else begin
            for (int r = 0; r < R; r++) begin
                m_xv[r] = acc[r];
                if (acc[r]) begin m_cred[r]--; m_xs[r] = who[r]; end
                if (credit_i[r]) begin
                    if (m_cred[r] == B) bad = 1;
                    else m_cred[r]++;
                end
            end
            m_err = m_err | bad;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i = '0; out_port_i = '0; grants_i = '0; credit_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_credits", 64'(credits_o), {40'd0, {R{4'd8}}});
        chk("rst_requests", 64'(requests_o), 64'd0);
        chk("rst_xv", 64'(xbar_valid_o), 64'd0);
        chk("rst_err", 64'(error_o), 64'd0);

        // Single grant, zero-latency pop, one-cycle crossbar setup.
        tick();
        valid_i = 4'b0001; out_port_i[0] = 3'd2; grants_i[0] = 6'b000100;
        @(negedge clk);
        chk("t2_req0", 64'(requests_o[0]), 64'(6'b000100));
        chk("t2_read", 64'(read_o), 64'(4'b0001));
        tick();
        idle();
        @(negedge clk);
        chk("t2_xv2", 64'(xbar_valid_o[2]), 64'd1);
        chk("t2_xs2", 64'(xbar_sel_o[2]), 64'd0);
        chk("t2_cred2", 64'(credits_o[2]), 64'd7);
        tick();

        // Drain output 1 to zero credits, then recover with one return.
        valid_i = 4'b1000; out_port_i[3] = 3'd1; grants_i[3] = 6'b000010;
        repeat (8) tick();
        grants_i = '0;
        @(negedge clk);
        chk("t3_cred1", 64'(credits_o[1]), 64'd0);
        chk("t3_req3", 64'(requests_o[3]), 64'd0);
        chk("t3_read3", 64'(read_o[3]), 64'd0);
        tick();
        credit_i[1] = 1'b1;
        tick();
        credit_i = '0;
        @(negedge clk);
        chk("t3_cred1_ret", 64'(credits_o[1]), 64'd1);
        chk("t3_req3_back", 64'(requests_o[3]), 64'(6'b000010));
        tick();
        idle();

        // Debit plus return in one cycle, then saturating return.
        valid_i = 4'b0100; out_port_i[2] = 3'd4; grants_i[2] = 6'b010000;
        repeat (3) tick();
        credit_i[4] = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("t4_cred4", 64'(credits_o[4]), 64'd5);
        chk("t4_err0", 64'(error_o), 64'd0);
        credit_i[4] = 1'b1;
        repeat (4) tick();
        credit_i = '0;
        @(negedge clk);
        chk("t4_cred4_sat", 64'(credits_o[4]), 64'd8);
        chk("t4_err1", 64'(error_o), 64'd1);

        // Clear error; two outputs granted together, out-of-range route quiet.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_i = 4'b0111; out_port_i[0] = 3'd1; out_port_i[1] = 3'd3; out_port_i[2] = 3'd7;
        grants_i[0] = 6'b000010; grants_i[1] = 6'b001000;
        @(negedge clk);
        chk("t5_req2", 64'(requests_o[2]), 64'd0);
        chk("t5_read", 64'(read_o), 64'(4'b0011));
        tick();
        idle();
        @(negedge clk);
        chk("t5_xv", 64'(xbar_valid_o), 64'(6'b001010));
        chk("t5_xs3", 64'(xbar_sel_o[3]), 64'd1);
        chk("t5_err0", 64'(error_o), 64'd0);

        // Stray grant.
        grants_i[1] = 6'b000001;
        @(negedge clk);
        chk("t6_read1", 64'(read_o[1]), 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("t6_err", 64'(error_o), 64'd1);
        chk("t6_cred0", 64'(credits_o[0]), 64'd8);

        // Double legal grant on column 5.
        valid_i = 4'b0101; out_port_i[0] = 3'd5; out_port_i[2] = 3'd5;
        grants_i[0] = 6'b100000; grants_i[2] = 6'b100000;
        @(negedge clk);
        chk("t7_req0", 64'(requests_o[0]), 64'(6'b100000));
        chk("t7_read", 64'(read_o), 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("t7_cred5", 64'(credits_o[5]), 64'd8);
        chk("t7_xv5", 64'(xbar_valid_o[5]), 64'd0);

        // Reset in the middle of traffic.
        valid_i = 4'b0010; out_port_i[1] = 3'd0; grants_i[1] = 6'b000001;
        repeat (5) tick();
        @(negedge clk);
        chk("t8_cred0", 64'(credits_o[0]), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("t8_cred0_rst", 64'(credits_o[0]), 64'd8);
        chk("t8_xv_rst", 64'(xbar_valid_o), 64'd0);
        chk("t8_err_rst", 64'(error_o), 64'd0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
